// File: rtl/sadd_pkg.sv
// Shared definitions for the bit-serial adder receive path:
// FSM state encoding, default operand width and counter sizing.
package sadd_pkg;

    // Default operand/sum width in bits (also bits per frame).
    localparam int SADD_WIDTH = 8;

    // Bit counter width: must hold values 0..WIDTH-1 with headroom.
    function automatic int sadd_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int SADD_CNT_W = sadd_cnt_w(SADD_WIDTH);

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sadd_state_e;

endpackage

// File: rtl/sadd_fa_bit.sv
// Single-bit combinational full adder used as the serial adder's ALU.
module sadd_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sadd_serial_rx.sv
// Receive end of the bit-serial operand link. Two LSB-first operand streams
// are added one bit per qualified edge; the completed sum is presented on
// pout with a one-cycle valid pulse.
//
// Optional feature macro: SADD_SUB_EN
//   defined   -> port 'sub' exists; sub=1 at start computes A-B
//                (B inverted, carry-in 1, cout=1 means no borrow).
//   undefined -> addition only, carry-in always 0.
//
// Handshake: start is accepted only in IDLE (busy=0, valid=0); bit 0 is
// sampled on that edge. Bits 1..WIDTH-1 are sampled on edges with enable=1.
// valid is a single-cycle pulse after the edge sampling bit WIDTH-1; pout and
// cout hold until the next completion. There is no backpressure.
module sadd_serial_rx
    import sadd_pkg::*;
#(
    parameter int WIDTH = SADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    input  logic             sin_a,
    input  logic             sin_b,
`ifdef SADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] pout,
    output logic             cout,
    output logic             valid,
    output logic             busy
);

    localparam int            CW   = sadd_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sadd_state_e      state_q;
    sadd_state_e      state_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    // Holds the upper WIDTH-1 bits of the partial sum; the newest bit comes
    // straight from the adder, so the full WIDTH-bit shadow is {fa_s, shadow_q}.
    logic [WIDTH-2:0] shadow_q;
    logic [WIDTH-1:0] shadow_full;

    logic accept;
    logic shift_en;
    logic last_bit;
    logic take_bit;
    logic fa_b;
    logic fa_cin;
    logic fa_s;
    logic fa_cout;

`ifdef SADD_SUB_EN
    logic sub_q;
    logic inv_b;
    // Operation is latched at start; the live port only matters on that edge.
    assign inv_b  = accept ? sub : sub_q;
    assign fa_b   = sin_b ^ inv_b;
    assign fa_cin = accept ? sub : carry_q;
`else
    assign fa_b   = sin_b;
    assign fa_cin = accept ? 1'b0 : carry_q;
`endif

    assign take_bit    = accept | shift_en;
    assign shadow_full = {fa_s, shadow_q};

    sadd_fa_bit u_fa (
        .a    (sin_a),
        .b    (fa_b),
        .cin  (fa_cin),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shift_en = 1'b0;
        last_bit = 1'b0;
        valid    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start;
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = enable;
                last_bit = enable && (cnt_q == LAST);
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit counter, carry flop, shadow shift and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            shadow_q <= '0;
            pout     <= '0;
            cout     <= 1'b0;
`ifdef SADD_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else if (take_bit) begin
            carry_q  <= fa_cout;
            shadow_q <= shadow_full[WIDTH-1:1];
            if (accept) begin
                cnt_q <= CW'(1);
`ifdef SADD_SUB_EN
                sub_q <= sub;
`endif
            end else if (last_bit) begin
                cnt_q <= '0;
                pout  <= shadow_full;
                cout  <= fa_cout;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sadd_serial_rx.sv
// Directed plus randomized bench for sadd_serial_rx with an arithmetic
// reference model (A+B or A+~B+1 modulo 2^W, carry in bit W).
module tb_sadd_serial_rx;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         enable;
    logic         sin_a;
    logic         sin_b;
`ifdef SADD_SUB_EN
    logic         sub;
`endif
    logic [W-1:0] pout;
    logic         cout;
    logic         valid;
    logic         busy;

    int           checks   = 0;
    int           failures = 0;
    logic [W:0]   last_exp = '0;

    sadd_serial_rx #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .enable (enable),
        .sin_a  (sin_a),
        .sin_b  (sin_b),
`ifdef SADD_SUB_EN
        .sub    (sub),
`endif
        .pout   (pout),
        .cout   (cout),
        .valid  (valid),
        .busy   (busy)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference result: {carry, sum} from plain arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic subv);
        logic [W:0] r;
        if (subv) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else      r = {1'b0, a} + {1'b0, b};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams one frame starting in an IDLE cycle; returns in the DONE cycle
    // (or mid-frame after an asynchronous reset when abort_pos is hit).
    task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b, input logic subv,
                             input int stall_pos, input int stall_len,
                             input int restart_pos, input int abort_pos);
        logic [W:0] exp;
        int         idx;
        int         stalls;
        int         edges;
        logic       adv;
        exp    = model(a, b, subv);
        start  = 1'b1;
        sin_a  = a[0];
        sin_b  = b[0];
        enable = 1'($urandom_range(0, 1));
`ifdef SADD_SUB_EN
        sub    = subv;
`endif
        @(posedge clk); #1;
        edges = 1;
        start = 1'b0;
`ifdef SADD_SUB_EN
        sub   = 1'($urandom_range(0, 1));
`endif
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_after_start", 32'(valid), 32'd0);
        idx    = 1;
        stalls = 0;
        while (idx < W) begin
            if (idx == abort_pos) begin
                rst = 1'b1;
                #1;
                chk("abort_pout", 32'(pout), 32'd0);
                chk("abort_cout", 32'(cout), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_valid", 32'(valid), 32'd0);
                #2;
                rst      = 1'b0;
                enable   = 1'b0;
                last_exp = '0;
                return;
            end
            if (idx == stall_pos && stalls < stall_len) begin
                enable = 1'b0;
                sin_a  = 1'($urandom);
                sin_b  = 1'($urandom);
                adv    = 1'b0;
                stalls++;
            end else begin
                enable = 1'b1;
                sin_a  = a[idx];
                sin_b  = b[idx];
                adv    = 1'b1;
            end
            start = (idx == restart_pos);
            @(posedge clk); #1;
            edges++;
            start = 1'b0;
            if (adv) idx++;
            if (idx < W) begin
                chk("busy_mid", 32'(busy), 32'd1);
                chk("valid_mid", 32'(valid), 32'd0);
            end
        end
        chk("valid_done", 32'(valid), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("pout", 32'(pout), 32'(exp[W-1:0]));
        chk("cout", 32'(cout), 32'(exp[W]));
        chk("latency", 32'(edges), 32'(W + stalls));
        last_exp = exp;
    endtask

    // One cycle after DONE (or after an abort); poke=1 drives a start that
    // lands in the DONE cycle and must be ignored.
    task automatic gap(input logic poke);
        start  = poke;
        enable = 1'($urandom_range(0, 1));
        sin_a  = 1'($urandom);
        sin_b  = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        chk("gap_valid", 32'(valid), 32'd0);
        chk("gap_busy", 32'(busy), 32'd0);
        chk("gap_pout_hold", 32'(pout), 32'(last_exp[W-1:0]));
        chk("gap_cout_hold", 32'(cout), 32'(last_exp[W]));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           sp;
        int           sl;

        rst    = 1'b1;
        start  = 1'b0;
        enable = 1'b0;
        sin_a  = 1'b0;
        sin_b  = 1'b0;
`ifdef SADD_SUB_EN
        sub    = 1'b0;
`endif
        #12;
        chk("reset_pout", 32'(pout), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 0xAA + 0x55, no stalls.
        run_frame(8'hAA, 8'h55, 1'b0, -1, 0, -1, -1);
        gap(1'b0);

        // Carry out, then a start landing in DONE (ignored), then next frame.
        run_frame(8'hFF, 8'h01, 1'b0, -1, 0, -1, -1);
        gap(1'b1);
        run_frame(8'h0F, 8'h01, 1'b0, -1, 0, -1, -1);
        gap(1'b0);

        // Three-cycle stall in the middle of the frame.
        run_frame(8'h3C, 8'h12, 1'b0, 4, 3, -1, -1);
        gap(1'b0);

        // start re-pulsed while bit 4 is sampled.
        run_frame(8'h5A, 8'h33, 1'b0, -1, 0, 4, -1);
        gap(1'b0);

        // Leave a nonzero result, then reset after bit 5 of the next frame.
        run_frame(8'h77, 8'h11, 1'b0, -1, 0, -1, -1);
        gap(1'b0);
        run_frame(8'h12, 8'h34, 1'b0, -1, 0, -1, 6);
        @(posedge clk); #1;
        chk("post_abort_valid", 32'(valid), 32'd0);
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_pout", 32'(pout), 32'd0);
        run_frame(8'h01, 8'h01, 1'b0, -1, 0, -1, -1);
        gap(1'b0);

`ifdef SADD_SUB_EN
        run_frame(8'h10, 8'h01, 1'b1, -1, 0, -1, -1);
        gap(1'b0);
        run_frame(8'h01, 8'h02, 1'b1, -1, 0, -1, -1);
        gap(1'b0);
`endif

        // Randomized frames with random stalls.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            sp = $urandom_range(1, W - 1);
            sl = $urandom_range(0, 3);
            run_frame(ra, rb, rs, sp, sl, -1, -1);
            gap(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
